// File: rtl/mole_cmd_queue.sv
// ---------------------------------------------------------------------------
// mole_cmd_queue
//
// Command decoder and queue between the UART byte receiver and the mole game
// controller. Raw rx bytes become typed game commands: hole hits 'A'..'P',
// start 'S' and abort 'X'. Repeated hits on one hole inside a holdoff window
// are suppressed. Commands are buffered in a small register FIFO and offered
// on a valid/ready interface. Everything runs on the UART clock.
//
// Pipeline:
//   edge 1  decode register (class + index of the strobed byte)
//   edge 2  holdoff filter and FIFO write
//
// Optional feature macro:
//   MOLE_CMD_LOWERCASE_EN  when defined, 'a'..'p', 's', 'x' decode the same
//                          as their uppercase forms; otherwise lowercase
//                          bytes are out of set and discarded.
//
// Parameters:
//   FIFO_DEPTH   command FIFO entries, power of two, 2..16
//   HOLDOFF_CYC  cycles during which a repeat hit on the same hole is ignored
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous reset, active-high
//   i_rx_data     received byte, valid while i_rx_data_en = 1
//   i_rx_data_en  one-cycle strobe per received byte
//   o_cmd_valid   FIFO head holds a command
//   i_cmd_ready   consumer accepts head when o_cmd_valid & i_cmd_ready
//   o_cmd_type    0 = HIT, 1 = START, 2 = ABORT
//   o_cmd_idx     hole index 0..15 for HIT, 0 otherwise
//   o_fifo_level  number of queued commands
//   o_drop_cnt    commands lost to FIFO overflow, saturating at 255
// ---------------------------------------------------------------------------
module mole_cmd_queue #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLDOFF_CYC = 2_500_000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_data_en,
    output logic                          o_cmd_valid,
    input  logic                          i_cmd_ready,
    output logic [1:0]                    o_cmd_type,
    output logic [3:0]                    o_cmd_idx,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [7:0]                    o_drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] TYPE_HIT   = 2'd0;
    localparam logic [1:0] TYPE_START = 2'd1;
    localparam logic [1:0] TYPE_ABORT = 2'd2;

    // Decode
    logic [7:0]  w_folded;
    logic        w_dec_valid;
    logic [1:0]  w_dec_type;
    logic [3:0]  w_dec_idx;

    // Stage 1 register
    logic        r_s1_valid;
    logic [1:0]  r_s1_type;
    logic [3:0]  r_s1_idx;

    // Holdoff state
    logic [31:0] r_hold_cnt;
    logic [3:0]  r_last_idx;

    // FIFO state
    logic [5:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [7:0]    r_drop_cnt;

    logic w_repeat;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_write;
    logic w_drop;
    logic w_valid;

    // Classify the incoming byte. Lowercase letters are folded onto uppercase
    // only when the lowercase feature is built in. Hole index for 'A'..'P'
    // is the low nibble minus one ('A' = 0x41 -> 0, 'P' = 0x50 -> 15).
    always_comb begin
        w_folded = i_rx_data;
`ifdef MOLE_CMD_LOWERCASE_EN
        if (i_rx_data >= 8'h61 && i_rx_data <= 8'h7A) begin
            w_folded = i_rx_data - 8'h20;
        end
`else
`endif
        w_dec_valid = 1'b0;
        w_dec_type  = TYPE_HIT;
        w_dec_idx   = 4'd0;
        if (i_rx_data_en) begin
            if (w_folded >= 8'h41 && w_folded <= 8'h50) begin
                w_dec_valid = 1'b1;
                w_dec_idx   = w_folded[3:0] - 4'd1;
            end else if (w_folded == 8'h53) begin
                w_dec_valid = 1'b1;
                w_dec_type  = TYPE_START;
            end else if (w_folded == 8'h58) begin
                w_dec_valid = 1'b1;
                w_dec_type  = TYPE_ABORT;
            end
        end
    end

    // Stage 1: capture the decoded command; out-of-set bytes leave no trace.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_type  <= TYPE_HIT;
            r_s1_idx   <= 4'd0;
        end else begin
            r_s1_valid <= w_dec_valid;
            r_s1_type  <= w_dec_type;
            r_s1_idx   <= w_dec_idx;
        end
    end

    // A hit is a repeat only if it names the remembered hole while the
    // holdoff window is still open; START/ABORT are never filtered.
    assign w_repeat = r_s1_valid && (r_s1_type == TYPE_HIT) &&
                      (r_s1_idx == r_last_idx) && (r_hold_cnt != 32'd0);
    assign w_push   = r_s1_valid && !w_repeat;

    assign w_valid  = (r_level != '0);
    assign w_pop    = w_valid && i_cmd_ready;
    assign w_full   = (r_level == LW'(FIFO_DEPTH));
    // When full, a simultaneous pop frees the slot the push needs.
    assign w_write  = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    // Holdoff window: an accepted hit opens it and remembers the hole,
    // START/ABORT close it, otherwise it counts down to zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_cnt <= 32'd0;
            r_last_idx <= 4'd0;
        end else if (w_push && (r_s1_type == TYPE_HIT)) begin
            r_hold_cnt <= 32'(HOLDOFF_CYC);
            r_last_idx <= r_s1_idx;
        end else if (w_push) begin
            r_hold_cnt <= 32'd0;
        end else if (r_hold_cnt != 32'd0) begin
            r_hold_cnt <= r_hold_cnt - 32'd1;
        end
    end

    // FIFO storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {r_s1_type, r_s1_idx};
        end
    end

    // Pointers wrap naturally because the depth is a power of two; the level
    // counter carries one extra bit to represent a completely full FIFO.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_write && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_write && w_pop) begin
                r_level <= r_level - LW'(1);
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign o_cmd_valid  = w_valid;
    assign o_cmd_type   = w_valid ? r_mem[r_rd_ptr][5:4] : TYPE_HIT;
    assign o_cmd_idx    = w_valid ? r_mem[r_rd_ptr][3:0] : 4'd0;
    assign o_fifo_level = r_level;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_mole_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_mole_cmd_queue
//
// Directed bench for mole_cmd_queue with FIFO_DEPTH = 4 and HOLDOFF_CYC = 20.
// Each accepted command is pushed onto a scoreboard queue when its byte is
// driven; a monitor pops and compares whenever the consumer handshake fires.
// Honours MOLE_CMD_LOWERCASE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mole_cmd_queue;

    localparam int FIFO_DEPTH  = 4;
    localparam int HOLDOFF_CYC = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rxData = 8'h00;
    logic       rxDataEn = 1'b0;
    logic       cmdReady = 1'b0;
    logic       cmdValid;
    logic [1:0] cmdType;
    logic [3:0] cmdIdx;
    logic [2:0] fifoLevel;
    logic [7:0] dropCnt;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] scoreboard [$];

    mole_cmd_queue #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLDOFF_CYC (HOLDOFF_CYC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_data    (rxData),
        .i_rx_data_en (rxDataEn),
        .o_cmd_valid  (cmdValid),
        .i_cmd_ready  (cmdReady),
        .o_cmd_type   (cmdType),
        .o_cmd_idx    (cmdIdx),
        .o_fifo_level (fifoLevel),
        .o_drop_cnt   (dropCnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one byte strobe across one active edge.
    task automatic applyStimulus(input logic [7:0] b);
        rxData   = b;
        rxDataEn = 1'b1;
        tick();
        rxDataEn = 1'b0;
        rxData   = 8'h00;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (scoreboard.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(scoreboard.size()), 32'd0);
    endtask

    // Monitor samples mid-cycle; the pop happens on the following edge.
    always @(negedge clk) begin
        if (!rst && cmdValid && cmdReady) begin
            if (scoreboard.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL unexpectedCmd observed=%0h expected=none", {cmdType, cmdIdx});
            end else begin
                checkOutput("cmdOut", 32'({cmdType, cmdIdx}), 32'(scoreboard.pop_front()));
            end
        end
    end

    initial begin
        bit sawValid;

        // Reset state and idle
        cmdReady = 1'b1;
        #2;
        checkOutput("rstValid", 32'(cmdValid), 32'd0);
        checkOutput("rstType",  32'(cmdType),  32'd0);
        checkOutput("rstIdx",   32'(cmdIdx),   32'd0);
        checkOutput("rstLevel", 32'(fifoLevel), 32'd0);
        checkOutput("rstDrop",  32'(dropCnt),  32'd0);
        tick();
        rst = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cmdValid) sawValid = 1'b1;
        end
        checkOutput("idleValid", 32'(sawValid), 32'd0);

        // Single hit 'C': valid appears two edges after the strobe edge
        scoreboard.push_back({2'd0, 4'd2});
        applyStimulus("C");
        checkOutput("cLatency1", 32'(cmdValid), 32'd0);
        tick();
        checkOutput("cValid", 32'(cmdValid), 32'd1);
        checkOutput("cType",  32'(cmdType),  32'd0);
        checkOutput("cIdx",   32'(cmdIdx),   32'd2);
        tick();
        checkOutput("cOneCycle", 32'(cmdValid), 32'd0);

        // Holdoff on repeated 'E'
        scoreboard.push_back({2'd0, 4'd4});
        applyStimulus("E");
        repeat (9) tick();
        applyStimulus("E");
        repeat (29) tick();
        scoreboard.push_back({2'd0, 4'd4});
        applyStimulus("E");
        repeat (30) tick();
        scoreboard.push_back({2'd0, 4'd4});
        scoreboard.push_back({2'd0, 4'd5});
        applyStimulus("E");
        applyStimulus("F");
        waitDrain("holdoffDrain");
        repeat (3) tick();
        checkOutput("holdoffEmpty", 32'(cmdValid), 32'd0);

        // Overflow with consumer stalled
        cmdReady = 1'b0;
        for (int i = 0; i < 4; i++) scoreboard.push_back({2'd0, 4'(i)});
        applyStimulus("A");
        applyStimulus("B");
        applyStimulus("C");
        applyStimulus("D");
        applyStimulus("S");
        applyStimulus("X");
        repeat (3) tick();
        checkOutput("ovfLevel", 32'(fifoLevel), 32'd4);
        checkOutput("ovfDrop",  32'(dropCnt),   32'd2);
        checkOutput("ovfHold",  32'({cmdValid, cmdType, cmdIdx}), 32'({1'b1, 2'd0, 4'd0}));
        cmdReady = 1'b1;
        waitDrain("ovfDrain");
        tick();
        checkOutput("ovfEmpty", 32'(cmdValid), 32'd0);

        // Push and pop on the same edge while full
        cmdReady = 1'b0;
        for (int i = 6; i < 10; i++) scoreboard.push_back({2'd0, 4'(i)});
        scoreboard.push_back({2'd1, 4'd0});
        applyStimulus("G");
        applyStimulus("H");
        applyStimulus("I");
        applyStimulus("J");
        tick();
        checkOutput("fullLevel", 32'(fifoLevel), 32'd4);
        applyStimulus("S");
        cmdReady = 1'b1;
        tick();
        checkOutput("pushPopLevel", 32'(fifoLevel), 32'd4);
        checkOutput("pushPopDrop",  32'(dropCnt),   32'd2);
        waitDrain("pushPopDrain");

        // Out-of-set bytes
        cmdReady = 1'b0;
        applyStimulus("Z");
        applyStimulus(8'h00);
        applyStimulus("q");
        repeat (3) tick();
        checkOutput("oosLevel", 32'(fifoLevel), 32'd0);
        checkOutput("oosDrop",  32'(dropCnt),   32'd2);
`ifdef MOLE_CMD_LOWERCASE_EN
        scoreboard.push_back({2'd2, 4'd0});
        applyStimulus("x");
        repeat (3) tick();
        checkOutput("lowerXLevel", 32'(fifoLevel), 32'd1);
`else
        applyStimulus("x");
        repeat (3) tick();
        checkOutput("lowerXLevel", 32'(fifoLevel), 32'd0);
`endif
        cmdReady = 1'b1;
        waitDrain("lowerDrain");

        // Reset while commands are queued
        cmdReady = 1'b0;
        applyStimulus("K");
        applyStimulus("L");
        applyStimulus("M");
        repeat (3) tick();
        checkOutput("preRstLevel", 32'(fifoLevel), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        scoreboard.delete();
        checkOutput("midRstLevel", 32'(fifoLevel), 32'd0);
        checkOutput("midRstValid", 32'(cmdValid),  32'd0);
        checkOutput("midRstDrop",  32'(dropCnt),   32'd0);
        checkOutput("midRstHead",  32'({cmdType, cmdIdx}), 32'd0);
        tick();
        rst = 1'b0;
        cmdReady = 1'b1;
        scoreboard.push_back({2'd0, 4'd10});
        applyStimulus("K");
        waitDrain("postRstDrain");
        tick();
        checkOutput("finalEmpty", 32'(cmdValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
